// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared constants, packed-window type and index helper for the
//                5x5 convolution datapath (window generator and conv consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int KERNEL = 5;
    localparam int PIX_W  = 8;
    localparam int WIN_W  = KERNEL * KERNEL * PIX_W;

    // Packed 5x5 window: pixel k = r*KERNEL + c lives at [PIX_W*k +: PIX_W]
    typedef logic [WIN_W-1:0] win_t;

    // Flat pixel index of window row r, column c
    function automatic int win_idx(input int r, input int c);
        return r * KERNEL + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_line_buffer
//  Description : One image line of pixel storage. Single port, read-before-
//                write: the read data is the old contents of the addressed
//                entry in the same cycle the new value is written.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int DW    = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Contents carry no reset: they are never observed before being refilled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Asynchronous read returns the pre-write value of this cycle
    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/conv_window_gen_5x5.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_gen_5x5
//  Description : Raster pixel stream to 5x5 sliding-window producer. Four
//                chained line buffers feed a 5x5 shift window; every fully
//                interior window is presented through a single output slot
//                with valid/ready handshaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen_5x5
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    output logic             win_valid,
    input  logic             win_ready,
    output win_t             pixels_out,
    output logic [XW-1:0]    win_x,
    output logic [YW-1:0]    win_y,
    output logic             frame_done
);

    localparam int c_NLB = KERNEL - 1;

    logic [XW-1:0]    r_col;
    logic [YW-1:0]    r_row;
    logic [XW-1:0]    w_col;
    logic [YW-1:0]    w_row;
    logic             w_acc;
    logic             w_emit;
    logic             w_col_last;
    logic             w_row_last;

    logic [PIX_W-1:0] w_lb_rd  [c_NLB];
    logic [PIX_W-1:0] w_lb_wr  [c_NLB];
    logic [PIX_W-1:0] w_new_col[KERNEL];
    logic [PIX_W-1:0] r_win    [KERNEL][KERNEL];
    logic [PIX_W-1:0] w_win_nxt[KERNEL][KERNEL];
    win_t             w_win_flat;

    logic             r_win_valid;
    win_t             r_pixels;
    logic [XW-1:0]    r_win_x;
    logic [YW-1:0]    r_win_y;
    logic             r_frame_done;

    // Accept, effective position (SOF forces 0,0) and emit decision
    always_comb begin
        w_acc      = pix_valid && pix_ready;
        w_col      = pix_sof ? '0 : r_col;
        w_row      = pix_sof ? '0 : r_row;
        w_col_last = (w_col == XW'(IMG_W - 1));
        w_row_last = (w_row == YW'(IMG_H - 1));
        w_emit     = w_acc && (w_row >= YW'(KERNEL - 1)) && (w_col >= XW'(KERNEL - 1));
    end

    // Line buffer chain: each stage is fed by the old contents of the previous
    always_comb begin
        w_lb_wr[0] = pix_data;
        for (int i = 1; i < c_NLB; i++) begin
            w_lb_wr[i] = w_lb_rd[i-1];
        end
    end

    generate
        for (genvar g = 0; g < c_NLB; g++) begin : g_lb
            conv_line_buffer #(
                .DEPTH (IMG_W),
                .DW    (PIX_W)
            ) u_lb (
                .clk     (clk),
                .i_we    (w_acc),
                .i_addr  (w_col),
                .i_wdata (w_lb_wr[g]),
                .o_rdata (w_lb_rd[g])
            );
        end
    endgenerate

    // Next window: shift rows left, append the incoming column (oldest row on top)
    always_comb begin
        for (int r = 0; r < c_NLB; r++) begin
            w_new_col[r] = w_lb_rd[c_NLB-1-r];
        end
        w_new_col[KERNEL-1] = pix_data;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                w_win_nxt[r][c] = r_win[r][c+1];
            end
            w_win_nxt[r][KERNEL-1] = w_new_col[r];
        end
    end

    // Flatten the next window into the consumer's packing
    always_comb begin
        w_win_flat = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                w_win_flat[win_idx(r, c)*PIX_W +: PIX_W] = w_win_nxt[r][c];
            end
        end
    end

    // Raster position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Window shift register; contents are don't-care until four lines exist
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_win <= w_win_nxt;
        end
    end

    // Single output slot: load on emit, hold until handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid  <= 1'b0;
            r_pixels     <= '0;
            r_win_x      <= '0;
            r_win_y      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_acc && w_col_last && w_row_last;
            if (w_emit) begin
                r_win_valid <= 1'b1;
                r_pixels    <= w_win_flat;
                r_win_x     <= w_col - XW'(KERNEL - 1);
                r_win_y     <= w_row - YW'(KERNEL - 1);
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign pix_ready  = !(r_win_valid && !win_ready);
    assign win_valid  = r_win_valid;
    assign pixels_out = r_pixels;
    assign win_x      = r_win_x;
    assign win_y      = r_win_y;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen_5x5.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_gen_5x5
//  Description : Self-checking bench for conv_window_gen_5x5 on an 8x8 image,
//                against an image-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen_5x5;
    import conv_pkg::*;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_data;
    logic          pix_sof;
    logic          win_valid;
    logic          win_ready;
    win_t          pixels_out;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          frame_done;

    conv_window_gen_5x5 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .pixels_out (pixels_out),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the current frame as an image, plus expected output slot
    logic [7:0] img [H][W];
    int         mx, my;
    logic       m_valid;
    win_t       m_win;
    int         m_x, m_y;
    logic       m_fd;

    // Observed traffic
    win_t dq_win[$];
    int   dq_x[$], dq_y[$];
    win_t ref_win[$];
    int   ref_x[$], ref_y[$];
    int   n_fd;
    bit   rand_ready;
    int   gap;

    task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic win_t pack(input int x, input int y);
        win_t w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(r*5+c)*8 +: 8] = img[y-4+r][x-4+c];
        return w;
    endfunction

    function automatic logic pick_ready();
        if (rand_ready) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    // One clock: drive, check registered outputs and pix_ready, advance model
    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic wr, output logic acc);
        logic exp_ready;
        int   n;
        pix_valid = v; pix_data = d; pix_sof = s; win_ready = wr;
        #1;
        exp_ready = !(m_valid && !wr);
        chk("pix_ready", WIN_W'(pix_ready), WIN_W'(exp_ready));
        chk("win_valid", WIN_W'(win_valid), WIN_W'(m_valid));
        if (m_valid) begin
            chk("pixels_out", pixels_out, m_win);
            chk("win_x", WIN_W'(win_x), WIN_W'(m_x));
            chk("win_y", WIN_W'(win_y), WIN_W'(m_y));
        end
        chk("frame_done", WIN_W'(frame_done), WIN_W'(m_fd));
        if (win_valid && wr) begin
            dq_win.push_back(pixels_out);
            dq_x.push_back(int'(win_x));
            dq_y.push_back(int'(win_y));
        end
        if (frame_done) n_fd++;
        acc  = v && exp_ready;
        m_fd = 1'b0;
        if (acc) begin
            if (s) begin mx = 0; my = 0; end
            img[my][mx] = d;
            m_fd = (mx == W-1) && (my == H-1);
        end
        if (acc && mx >= 4 && my >= 4) begin
            m_valid = 1'b1; m_win = pack(mx, my); m_x = mx - 4; m_y = my - 4;
        end else if (wr) begin
            m_valid = 1'b0;
        end
        if (acc) begin
            n  = (my*W + mx + 1) % (W*H);
            mx = n % W; my = n / W;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic s);
        logic acc, dummy;
        int   budget;
        acc = 1'b0; budget = 0;
        while (!acc && budget < 200) begin
            step(1'b1, d, s, pick_ready(), acc);
            budget++;
        end
        if (!acc) begin
            n_assert++; n_fail++;
            $error("FAIL accept_timeout: observed no accept after %0d cycles, expected accept", budget);
        end
        for (int i = 0; i < gap; i++) step(1'b0, 8'h00, 1'b0, pick_ready(), dummy);
    endtask

    task automatic send_frame(input int kind);
        logic [7:0] d;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0:       d = 8'(y*W + x);
                    1:       d = 8'(255 - (y*W + x));
                    default: d = 8'($urandom);
                endcase
                send_pix(d, (x == 0) && (y == 0));
            end
    endtask

    task automatic drain();
        logic dummy;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, dummy);
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00; win_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = 1'b0; m_win = '0; m_x = 0; m_y = 0; m_fd = 1'b0; mx = 0; my = 0;
    endtask

    task automatic clr_stats();
        dq_win.delete(); dq_x.delete(); dq_y.delete(); n_fd = 0;
    endtask

    task automatic cmp_ref(input string tag);
        chk({tag, "_count"}, WIN_W'(dq_win.size()), WIN_W'(16));
        for (int i = 0; i < dq_win.size() && i < ref_win.size(); i++) begin
            chk({tag, "_win"}, dq_win[i], ref_win[i]);
            chk({tag, "_x"}, WIN_W'(dq_x[i]), WIN_W'(ref_x[i]));
            chk({tag, "_y"}, WIN_W'(dq_y[i]), WIN_W'(ref_y[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic dummy;
        rand_ready = 1'b0; gap = 0;
        do_reset();
        // Reset state
        chk("rst_win_valid", WIN_W'(win_valid), WIN_W'(0));
        chk("rst_pix_ready", WIN_W'(pix_ready), WIN_W'(1));
        chk("rst_pixels_out", pixels_out, '0);
        chk("rst_win_xy", WIN_W'({win_x, win_y}), WIN_W'(0));
        chk("rst_frame_done", WIN_W'(frame_done), WIN_W'(0));

        // 1: ramp frame, always ready
        clr_stats();
        send_frame(0); drain();
        chk("t1_count", WIN_W'(dq_win.size()), WIN_W'(16));
        if (dq_win.size() == 16) begin
            chk("t1_first_xy", WIN_W'({dq_x[0], dq_y[0]}), WIN_W'(0));
            chk("t1_first_p0", WIN_W'(dq_win[0][7:0]), WIN_W'(0));
            chk("t1_first_p4", WIN_W'(dq_win[0][39:32]), WIN_W'(4));
            chk("t1_first_p20", WIN_W'(dq_win[0][167:160]), WIN_W'(32));
            chk("t1_first_p24", WIN_W'(dq_win[0][199:192]), WIN_W'(36));
            chk("t1_last_x", WIN_W'(dq_x[15]), WIN_W'(3));
            chk("t1_last_y", WIN_W'(dq_y[15]), WIN_W'(3));
            chk("t1_last_p24", WIN_W'(dq_win[15][199:192]), WIN_W'(63));
        end
        chk("t1_frame_done", WIN_W'(n_fd), WIN_W'(1));
        ref_win = dq_win; ref_x = dq_x; ref_y = dq_y;

        // 2: random backpressure
        clr_stats(); rand_ready = 1'b1;
        send_frame(0); drain();
        cmp_ref("t2");
        rand_ready = 1'b0;

        // 3: back-to-back frames, second inverted
        clr_stats();
        send_frame(0); send_frame(1); drain();
        chk("t3_count", WIN_W'(dq_win.size()), WIN_W'(32));
        if (dq_win.size() == 32) begin
            chk("t3_f2_p0", WIN_W'(dq_win[16][7:0]), WIN_W'(255));
            chk("t3_f2_p24", WIN_W'(dq_win[16][199:192]), WIN_W'(219));
        end
        chk("t3_frame_done", WIN_W'(n_fd), WIN_W'(2));

        // 4: partial frame then SOF resync
        clr_stats();
        for (int i = 0; i < 20; i++) send_pix(8'(i), i == 0);
        send_frame(0); drain();
        cmp_ref("t4");
        if (dq_y.size() > 0) chk("t4_first_y", WIN_W'(dq_y[0]), WIN_W'(0));

        // 5: reset while a window is pending
        do_reset();
        for (int i = 0; i < 45; i++) send_pix(8'(i), i == 0);
        chk("t5_pending", WIN_W'(win_valid), WIN_W'(1));
        do_reset();
        chk("t5_win_valid", WIN_W'(win_valid), WIN_W'(0));
        chk("t5_pix_ready", WIN_W'(pix_ready), WIN_W'(1));
        chk("t5_win_xy", WIN_W'({win_x, win_y}), WIN_W'(0));
        clr_stats();
        send_frame(0); drain();
        cmp_ref("t5");

        // 6: sparse input, one beat every three cycles
        clr_stats(); gap = 2;
        send_frame(0); drain();
        cmp_ref("t6");
        gap = 0;

        // 7: random pixels with random backpressure
        clr_stats(); rand_ready = 1'b1;
        send_frame(2); drain();
        chk("t7_count", WIN_W'(dq_win.size()), WIN_W'(16));
        chk("t7_frame_done", WIN_W'(n_fd), WIN_W'(1));
        rand_ready = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b1, dummy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_window_gen_5x5.md
Name: conv_window_gen_5x5

Overview:
- Streaming producer for the 5x5 convolution datapath.
- Accepts a raster-order 8-bit pixel stream and buffers four image lines. It emits every fully-interior 5x5 neighbourhood as a 200-bit packed window, in the exact packing the conv consumer expects on its pixels_in port.
- Sits between the pixel source and the conv_5x5 array, and adds valid/ready flow control on both sides.

Parameters:
- IMG_W, 32, pixels per line; legal range >= 5.
- IMG_H, 32, lines per frame; legal range >= 5.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- pix_valid, input, 1, input beat valid.
- pix_ready, output, 1, block can accept an input beat.
- pix_data, input, 8, pixel value.
- pix_sof, input, 1, marks the first pixel of a frame; sampled only on an accepted beat.
- win_valid, output, 1, window output valid.
- win_ready, input, 1, downstream accepts the window.
- pixels_out, output, 200, packed window; pixel k sits at [8k+7:8k], with k = r*5 + c.
- win_x, output, clog2(IMG_W), window left column in the image.
- win_y, output, clog2(IMG_H), window top row in the image.
- frame_done, output, 1, one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: rst is synchronous and active-high.
  - pix_ready=1, win_valid=0, pixels_out=0, win_x=0, win_y=0, frame_done=0.
  - col=0, row=0.
  - Line-buffer and window contents are don't-care; they are never exposed before row>=4.
- Accept condition: a beat is accepted when pix_valid && pix_ready.
  - pix_ready = !(win_valid && !win_ready), i.e. a single output register slot.
- Counters, on each accepted beat:
  - col increments.
  - At col == IMG_W-1, col wraps to 0 and row increments.
  - At row == IMG_H-1 && col == IMG_W-1, both wrap to 0 and frame_done pulses on the next cycle.
- SOF resync: if pix_sof=1 on an accepted beat, that pixel is treated as col=0,row=0 regardless of the counter state, and the counters advance from there.
  - A pending output window is not affected.
  - Line-buffer contents are not cleared.
- Line buffers: four IMG_W x 8 memories, LB0..LB3, addressed by col.
  - On an accepted beat, read LB0..LB3[col], then write LB0[col]=pix_data and LBn[col]=old LB(n-1)[col].
  - LB3 therefore holds the line from 4 rows earlier.
- Window register: 5x5 bytes.
  - On an accepted beat, shift every row left by one column.
  - New column 4 is {r0=LB3 out, r1=LB2 out, r2=LB1 out, r3=LB0 out, r4=pix_data}.
  - Row 0 is the top (oldest) row; column 0 is the leftmost.
- Emit rule: if the accepted beat has row>=4 && col>=4, then on the next cycle:
  - win_valid=1;
  - pixels_out = the window including this pixel;
  - win_x = col-4, win_y = row-4.
- Output hold: win_valid stays high and all outputs stay stable until win_ready=1.
  - win_valid clears on handshake unless a new window loads in the same cycle, which is legal because pix_ready is high whenever win_ready is high.
- Latency and rate: latency is 1 cycle from the accepted beat to win_valid. Sustained rate is 1 pixel and 1 window per cycle with no bubbles.
- Window count: each frame produces (IMG_W-4)*(IMG_H-4) windows. Columns 0..3 and rows 0..3 never emit.
- Reset mid-frame: the output is dropped and the next accepted pixel is position (0,0). No partial window is emitted until 4 new lines have arrived.
- Back-to-back frames: handled with no idle cycle required.

Decomposition:
- Package conv_pkg:
  - KERNEL=5, PIX_W=8, WIN_W=KERNEL*KERNEL*PIX_W=200;
  - function win_idx(r,c)=r*KERNEL+c;
  - the packed-window typedef, shared with the conv consumer.
- Sub-module conv_line_buffer:
  - one IMG_W x 8 single-port read-before-write RAM;
  - instantiated 4 times and chained.

Test Plan:
1. Reset, then one IMG_W=8, IMG_H=8 frame of ramp pixels p=y*8+x with win_ready=1 -> the first win_valid comes 1 cycle after pixel 36 is accepted, with win_x=0, win_y=0, pixel[0]=0, pixel[4]=4, pixel[20]=32, pixel[24]=36.
   - Exactly 16 windows are produced.
   - The last window has win_x=3, win_y=3, pixel[24]=63.
   - frame_done pulses once.
2. Same frame with win_ready toggling at random, ~50% -> no window lost or duplicated, and pixels_out stable while stalled.
   - pix_ready=0 exactly when win_valid && !win_ready.
   - The window sequence matches test 1.
3. Two back-to-back 8x8 frames, the second with p=255-(y*8+x) -> 32 windows in total.
   - The second frame's first window has pixel[0]=255 and pixel[24]=219.
4. After 20 pixels of a frame, assert pix_sof on the next beat and send a full frame -> 16 windows, all matching test 1, with win_y=0 first.
5. Assert rst after 45 accepted pixels while win_valid=1 -> next cycle win_valid=0, pix_ready=1, win_x=win_y=0.
   - A following full frame reproduces test 1 exactly.
6. Send pix_valid with gaps (1 beat every 3 cycles) -> window count and contents are identical to test 1.
   - win_valid never asserts more than one window per accepted beat.
